// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the restoring divider: default operand width,
// iteration-counter sizing and the controller state encoding.
// No ports.
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // One extra bit so the counter can reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/addsub_n.sv
// ---------------------------------------------------------------------------
// addsub_n
// Combinational N-bit adder/subtractor.
//   a, b : operands
//   sub  : 1 -> y = a - b, 0 -> y = a + b (modulo 2**N)
//   y    : result
// ---------------------------------------------------------------------------
module addsub_n #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    // Subtraction as a + ~b + 1 so a single adder serves both operations.
    assign y = a + (b ^ {N{sub}}) + N'(sub);

endmodule

// File: rtl/div_restore_32.sv
// ---------------------------------------------------------------------------
// div_restore_32
// Unsigned restoring divider, one quotient bit per clock.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : begin a division (accepted in IDLE or DONE)
//   dividend    : numerator, sampled on the accepting edge
//   divisor     : denominator, sampled on the accepting edge
//   busy        : high while iterating
//   done        : one-cycle pulse, results valid
//   quotient    : result, held until the next accepted start
//   remainder   : result, held until the next accepted start
//   div_by_zero : set when the divisor was zero (quotient all-ones,
//                 remainder = dividend)
// ---------------------------------------------------------------------------
module div_restore_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state, state_n;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    logic accept;
    logic step;
    logic finish;
    logic zero_div;

    assign zero_div = (divisor == '0);

    // Partial remainder shifted left, taking in the next dividend bit.
    assign shifted = {rem_r, q_r[WIDTH-1]};

    addsub_n #(
        .N (WIDTH + 1)
    ) u_trial (
        .a   (shifted),
        .b   ({1'b0, dvsr}),
        .sub (1'b1),
        .y   (trial)
    );

    // A negative trial means shifted < divisor, so shifted fits in WIDTH bits.
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next   = {q_r[WIDTH-2:0], ~trial[WIDTH]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = zero_div ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvsr        <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvsr        <= divisor;
            rem_r       <= '0;
            q_r         <= dividend;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            // Zero divisor bypasses iteration; results are final immediately.
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (step) begin
            rem_r <= rem_next;
            q_r   <= q_next;
            cnt   <= cnt + 1'b1;
            if (finish) begin
                quotient  <= q_next;
                remainder <= rem_next;
            end
        end
    end

endmodule
